// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA/LUI shifter, at most STEP bits per clock,
// with a start/ready/valid handshake. Define SEQ_SHIFTER_ROTATE_EN to turn
// mode 3'b100 into rotate-right; otherwise that mode is a passthrough.
module seq_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STEP    = 4,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [2:0]         mode_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   result_o
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} op_e;

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] HALF_C = SHAMT_W'(WIDTH / 2);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic                 sign_q, sign_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [SHAMT_W-1:0]   k;
    logic [WIDTH-1:0]     shifted;
    logic [WIDTH-1:0]     ones;
`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [SHAMT_W:0]     wrap_amt;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    // One step of the latched operation by k = min(STEP, rem) bits
    always_comb begin
        ones    = '1;
        k       = (rem_q > STEP_C) ? STEP_C : rem_q;
        shifted = result_q;
`ifdef SEQ_SHIFTER_ROTATE_EN
        wrap_amt = (SHAMT_W + 1)'(WIDTH) - {1'b0, k};
`endif
        case (op_q)
            OP_SLL:  shifted = result_q << k;
            OP_SRL:  shifted = result_q >> k;
            OP_SRA:  shifted = (result_q >> k) | (sign_q ? ~(ones >> k) : '0);
`ifdef SEQ_SHIFTER_ROTATE_EN
            OP_ROR:  shifted = (result_q >> k) | (result_q << wrap_amt);
`endif
            default: shifted = result_q;
        endcase
    end

    // Next-state and register-update decode
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    result_d = a_i;
                    sign_d   = a_i[WIDTH-1];
                    rem_d    = shamt_i;
                    op_d     = OP_SLL;
                    // LUI is a fixed half-width SLL; passthrough modes need no steps
                    case (mode_i)
                        3'b000:  op_d = OP_SLL;
                        3'b001:  op_d = OP_SRL;
                        3'b010:  op_d = OP_SRA;
                        3'b011:  rem_d = HALF_C;
`ifdef SEQ_SHIFTER_ROTATE_EN
                        3'b100:  op_d = OP_ROR;
`endif
                        default: rem_d = '0;
                    endcase
                    state_d = (rem_d == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = shifted;
                    rem_d    = rem_q - k;
                    if (rem_d == '0) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ready_o  = (state_q == S_IDLE);
    assign busy_o   = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [4:0]  shamt_i = '0;
    logic [2:0]  mode_i = '0;
    logic        ready_o, busy_o, valid_o;
    logic [31:0] result_o;

    int n_chk = 0;
    int n_fail = 0;

    seq_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
        .a_i(a_i), .shamt_i(shamt_i), .mode_i(mode_i),
        .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Total shift distance an operation performs
    function automatic int rem_of(input logic [2:0] m, input int s);
        case (m)
            3'd0, 3'd1, 3'd2: return s;
            3'd3:             return 16;
`ifdef SEQ_SHIFTER_ROTATE_EN
            3'd4:             return s;
`endif
            default:          return 0;
        endcase
    endfunction

    // Value of operand a after shifting a total of p bits under mode m
    function automatic logic [31:0] mdl(input logic [31:0] a, input int p, input logic [2:0] m);
        case (m)
            3'd0, 3'd3: return a << p;
            3'd1:       return a >> p;
            3'd2:       return $unsigned($signed(a) >>> p);
`ifdef SEQ_SHIFTER_ROTATE_EN
            3'd4:       return (p == 0) ? a : ((a >> p) | (a << (32 - p)));
`endif
            default:    return a;
        endcase
    endfunction

    // Model: an accepted op is busy from its accept edge k through edge k+N,
    // valid in the cycle after edge k+N, N = ceil(rem/4).
    int          ecnt = 0;
    bit          m_act = 0;
    int          m_k = 0, m_N = 0, m_rem = 0;
    logic [31:0] m_exp = '0, m_res = '0, m_a = '0;
    logic [2:0]  m_mode = '0;

    always @(posedge clk or negedge rst_n) begin : model
        int  e, r, p;
        bit  was_busy;
        if (!rst_n) begin
            m_act <= 1'b0;
            m_res <= '0;
        end else begin
            e = ecnt + 1;
            ecnt <= e;
            was_busy = m_act && (e - 1) >= m_k && (e - 1) <= m_k + m_N;
            if (!was_busy) begin
                m_act <= 1'b0;
                if (start_i && !flush_i) begin
                    r = rem_of(mode_i, int'(shamt_i));
                    m_act  <= 1'b1;
                    m_k    <= e;
                    m_rem  <= r;
                    m_N    <= (r + 3) / 4;
                    m_a    <= a_i;
                    m_mode <= mode_i;
                    m_exp  <= mdl(a_i, r, mode_i);
                    m_res  <= mdl(a_i, r, mode_i);
                end
            end else if (flush_i) begin
                p = 4 * (e - 1 - m_k);
                if (p > m_rem) p = m_rem;
                m_act <= 1'b0;
                m_res <= mdl(m_a, p, m_mode);
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : compare
        bit b, v;
        b = m_act && ecnt >= m_k && ecnt <= m_k + m_N;
        v = b && (ecnt == m_k + m_N);
        chk("ready", {31'b0, ready_o}, {31'b0, !b});
        chk("busy",  {31'b0, busy_o},  {31'b0, b});
        chk("valid", {31'b0, valid_o}, {31'b0, v});
        if (v)       chk("result_valid", result_o, m_exp);
        else if (!b) chk("result_hold",  result_o, m_res);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and check latency and result against literals
    task automatic do_op(input string nm, input logic [31:0] a, input logic [4:0] s,
                         input logic [2:0] m, input logic [31:0] lit, input int lit_n,
                         input bit hold);
        int cnt;
        bit got;
        chk({"model_", nm}, mdl(a, rem_of(m, int'(s)), m), lit);
        a_i = a; shamt_i = s; mode_i = m; start_i = 1'b1;
        step();
        if (!hold) start_i = 1'b0;
        a_i = ~a; shamt_i = ~s; mode_i = m ^ 3'b001;
        cnt = 0; got = 0;
        while (!got && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (valid_o === 1'b1) got = 1;
        end
        chk({"lat_", nm}, cnt, lit_n + 1);
        chk({"res_", nm}, result_o, lit);
        step();
        start_i = 1'b0;
        step();
        chk({"idle_", nm}, {31'b0, ready_o}, 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_result", result_o, 32'h0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_busy",  {31'b0, busy_o},  32'd0);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        step();

        do_op("sll31",   32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000, 8, 0);
        do_op("sra5",    32'h8000_0000, 5'd5,  3'b010, 32'hFC00_0000, 2, 0);
        do_op("srl5",    32'h8000_0000, 5'd5,  3'b001, 32'h0400_0000, 2, 0);
        do_op("lui",     32'h1234_ABCD, 5'd7,  3'b011, 32'hABCD_0000, 4, 0);
        do_op("zero",    32'hDEAD_BEEF, 5'd0,  3'b000, 32'hDEAD_BEEF, 0, 0);
        do_op("pass7",   32'h1357_2468, 5'd9,  3'b111, 32'h1357_2468, 0, 0);
        do_op("sra_pos", 32'h7000_0000, 5'd7,  3'b010, 32'h00E0_0000, 2, 1);
        do_op("sra31",   32'hF000_0001, 5'd31, 3'b010, 32'hFFFF_FFFF, 8, 1);
        do_op("srl31",   32'hF000_0001, 5'd31, 3'b001, 32'h0000_0001, 8, 0);
`ifdef SEQ_SHIFTER_ROTATE_EN
        do_op("ror4",    32'h0000_00F1, 5'd4,  3'b100, 32'h1000_000F, 1, 0);
        do_op("ror9",    32'h0000_01FF, 5'd9,  3'b100, 32'hFF80_0000, 3, 0);
`else
        do_op("ror4",    32'h0000_00F1, 5'd4,  3'b100, 32'h0000_00F1, 0, 0);
`endif

        // Flush in the second SHIFT cycle: one 4-bit step done, then abandon
        a_i = 32'h0000_0001; shamt_i = 5'd31; mode_i = 3'b000; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_res",   result_o, 32'h0000_0010);
        chk("flush_ready", {31'b0, ready_o}, 32'd1);
        repeat (10) step();

        // Flush beats start in IDLE
        a_i = 32'h0000_0003; shamt_i = 5'd4; mode_i = 3'b000;
        start_i = 1'b1; flush_i = 1'b1;
        step();
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_idle_ready", {31'b0, ready_o}, 32'd1);
        chk("flush_idle_res",   result_o, 32'h0000_0010);
        step();

        // Asynchronous reset in the middle of a shift
        a_i = 32'h0000_0001; shamt_i = 5'd31; mode_i = 3'b000; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_result", result_o, 32'h0);
        chk("midrst_valid", {31'b0, valid_o}, 32'd0);
        chk("midrst_busy",  {31'b0, busy_o},  32'd0);
        chk("midrst_ready", {31'b0, ready_o}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) step();

        do_op("post_rst", 32'h0000_0F0F, 5'd8, 3'b000, 32'h000F_0F00, 2, 0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shifter for the MIPS32 datapath. It generalises the fixed LUI-style "immediate to upper half, zero-fill lower half" wiring into a configurable-width unit supporting SLL, SRL, SRA and LUI, shifting at most STEP bits per clock. It sits beside the ALU in the execute stage and uses a start/ready/valid handshake, so the pipeline control stalls on `busy_o`.

## Interface
- `WIDTH`, 32, operand/result width; must be even and ≥ 2·`STEP`.
- `STEP`, 4, maximum bits shifted per clock; power of two, ≤ `WIDTH`/2.
- `SHAMT_W`, $clog2(`WIDTH`), shift-amount width (derived; do not override).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request; accepted only on a rising edge where `ready_o`=1 and `flush_i`=0.
- `flush_i`  in  1  synchronous kill of any in-flight operation.
- `a_i`  in  `WIDTH`  operand; sampled on accept.
- `shamt_i`  in  `SHAMT_W`  shift amount; sampled on accept; ignored for LUI.
- `mode_i`  in  3  000 SLL, 001 SRL, 010 SRA, 011 LUI, 100 ROR (macro only); others = passthrough.
- `ready_o`  out  1  high in IDLE.
- `busy_o`  out  1  high in SHIFT or DONE.
- `valid_o`  out  1  one-cycle pulse; `result_o` is final while it is high.
- `result_o`  out  `WIDTH`  working/result register.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- On accept: load `a_i` into the working register, latch mode and sign bit `a_i[WIDTH-1]`, and set `rem` = `shamt_i`. For LUI, set `rem` = `WIDTH`/2 and mode = SLL. For a passthrough mode, set `rem` = 0.
- IDLE→DONE if `rem`=0; IDLE→SHIFT otherwise.
- SHIFT: each edge shifts by k = min(`STEP`, `rem`) and sets `rem` −= k. When `rem` becomes 0, go to DONE.
- Fill rules:
  - SLL/LUI: zero-fill on the right.
  - SRL: zero-fill on the left.
  - SRA: fill on the left with the latched sign bit.
  - ROR: the k LSBs wrap around to the MSBs.
- DONE: `valid_o`=1 for exactly one cycle, then →IDLE unconditionally.
- `result_o` updates on accept and on every SHIFT edge. It holds its value from DONE until the next accept.
- `flush_i`=1:
  - In SHIFT or DONE: →IDLE at the next edge; no `valid_o` is issued (a flush during DONE deasserts nothing retroactively; `valid_o` is combinational from the state); `result_o` holds.
  - In IDLE: `flush_i` beats `start_i`, so no accept.
- `start_i` while busy: ignored and not queued.
- Reset, asynchronous at any time including mid-operation: state IDLE, `result_o`=0, `rem`=0, latched mode/sign=0. Outputs under reset: `valid_o`=0, `busy_o`=0, `ready_o`=1.

## Timing
- Accept at edge k, with N = ceil(`rem`/`STEP`). Number of SHIFT edges = N.
- `valid_o` is high in the cycle after edge k+N. For `rem`=0, that is the cycle directly after the accept edge.
- `ready_o` returns high one cycle after `valid_o`.
- Minimum accept-to-accept interval = N+2 cycles.
- LUI at defaults (WIDTH=32, STEP=4): N=4, so `valid_o` comes 4 cycles after the accept edge.
- Worst case SLL of 31 at defaults: N=8.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- `SEQ_SHIFTER_ROTATE_EN` defined: mode 100 performs rotate-right by `shamt_i`, using the same stepping and latency as SRL.
- Not defined: mode 100 is passthrough (`rem`=0, result = `a_i`), and no rotate logic is synthesised.

## Test plan
- Reset behaviour: assert `rst_n`=0 mid-SHIFT -> `result_o`=0, `valid_o`=0, `busy_o`=0, `ready_o`=1 immediately. After release, IDLE with no spurious `valid_o`.
- SLL: `a_i`=0x0000_0001, `shamt_i`=31 -> 8 SHIFT cycles, then `valid_o` pulse with `result_o`=0x8000_0000, then `ready_o`=1 the next cycle.
- SRA vs SRL: `a_i`=0x8000_0000, `shamt_i`=5. SRA -> 0xFC00_0000 after 2 SHIFT cycles; SRL -> 0x0400_0000.
- LUI: `a_i`=0x1234_ABCD, `shamt_i`=7 (ignored) -> 0xABCD_0000 after 4 SHIFT cycles.
- Zero shift, busy start and flush:
  - `shamt_i`=0 -> `valid_o` in the cycle after accept, with `result_o`=`a_i`.
  - `start_i` held during SHIFT -> no extra operation.
  - `flush_i` in the second SHIFT cycle -> IDLE next edge and no `valid_o`.
- Rotate: with `SEQ_SHIFTER_ROTATE_EN` defined, ROR `a_i`=0x0000_00F1, `shamt_i`=4 -> 0x1000_000F. Without the macro, the same stimulus -> 0x0000_00F1 one cycle after accept.
